addsub_seq: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes on both sides. Each operation is processed CHUNK bits per clock through one shared CHUNK-bit carry-chain slice, trading latency for area at wide WIDTHs. The block is the wide-operand arithmetic unit for datapaths that exceed the fixed 8-bit adder. It reports the same flags as that adder: sum, unsigned carry/borrow, and signed overflow.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_chunk.sv | 29 ++
 rtl/addsub_seq.sv | 168 ++++++++++++++++
 tb/tb_addsub_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
// Saturating mode is selected in addsub_seq by defining ADDSUB_SATURATE_EN.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  // Width of a counter indexing n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit ripple-carry slice; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most significant chunk.
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_op,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cin_msb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b_op[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b_op[i]) | (w_c[i] & (a[i] ^ b_op[i]));
    end
  end

  assign cout    = w_c[CHUNK];
  assign cin_msb = w_c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement add/sub, CHUNK bits per clock through one slice.
// Define ADDSUB_SATURATE_EN to clamp the sum on signed overflow.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             over_flow
);

  localparam int unsigned     NCHUNK   = nchunk(WIDTH, CHUNK);
  localparam int unsigned     IW       = idx_w(NCHUNK);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NCHUNK - 1);

  generate
    if ((CHUNK == 0) || (NCHUNK == 0) || (WIDTH != NCHUNK * CHUNK)) begin : g_cfg_check
      $error("addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bop;
  logic             r_sel;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_merged;
  logic [WIDTH-1:0] w_sum_final;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = CALC;
      CALC:    if (r_idx == LAST_IDX) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_last    = (r_state == CALC) && (r_idx == LAST_IDX);

  // Select the operand chunk addressed by the running index.
  always_comb begin
    w_a_ch = '0;
    w_b_ch = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_ch = r_a[k*CHUNK +: CHUNK];
        w_b_ch = r_bop[k*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a       (w_a_ch),
    .b_op    (w_b_ch),
    .cin     (r_carry),
    .s       (w_s),
    .cout    (w_cout),
    .cin_msb (w_cin_msb)
  );

  assign w_ovf = w_cout ^ w_cin_msb;

  always_comb begin
    w_sum_merged = r_sum;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_idx == IW'(k)) begin
        w_sum_merged[k*CHUNK +: CHUNK] = w_s;
      end
    end
  end

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {WIDTH{1'b1}} >> 1;
  localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;

  // On overflow the true result carries the sign of operand a.
  always_comb begin
    w_sum_final = w_sum_merged;
    if (w_ovf) begin
      w_sum_final = r_a[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  assign w_sum_final = w_sum_merged;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_bop   <= '0;
      r_sel   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_bop   <= b ^ {WIDTH{sel}};
            r_sel   <= sel;
            r_carry <= sel;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_carry <= w_cout;
          if (w_last) begin
            r_sum  <= w_sum_final;
            r_cout <= w_cout ^ r_sel;
            r_ovf  <= w_ovf;
            r_idx  <= '0;
          end else begin
            r_sum  <= w_sum_merged;
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign over_flow = r_ovf;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq at WIDTH=32, CHUNK=8 (optionally ADDSUB_SATURATE_EN).
module tb_addsub_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        over_flow;

  int unsigned total  = 0;
  int unsigned passed = 0;

  addsub_seq #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .over_flow (over_flow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wait_out(input string tag, input int unsigned elat);
    int unsigned n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, elat);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input logic [31:0] esum, input logic ec, input logic ev);
    chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; sel = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb; sel = ~ts;
    chk({tag, ".out_valid_early"}, {31'd0, out_valid}, 32'd0);
    wait_out(tag, 4);
    chk({tag, ".sum"},       sum,                    esum);
    chk({tag, ".c_out"},     {31'd0, c_out},         {31'd0, ec});
    chk({tag, ".over_flow"}, {31'd0, over_flow},     {31'd0, ev});
    chk({tag, ".in_ready_done"}, {31'd0, in_ready},  32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready_after"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum",       sum,                32'd0);
    chk("rst.c_out",     {31'd0, c_out},     32'd0);
    chk("rst.over_flow", {31'd0, over_flow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
`else
    run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
`endif
    run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_equal",  32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run_op("add_carry8", 32'h00FF_FF80, 32'h0000_0080, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

    // Backpressure with a new request already waiting
    a = 32'h1111_1111; b = 32'h2222_2222; sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("bp1", 4);
    a = 32'h0000_0010; b = 32'h0000_0003; sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_sum",       sum,                32'h3333_3333);
      chk("bp.hold_valid",     {31'd0, out_valid}, 32'd1);
      chk("bp.hold_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp.hold_c_out",     {31'd0, c_out},     32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.in_ready_after_hs", {31'd0, in_ready},  32'd1);
    chk("bp.out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; sel = 1'b0;
    chk("bp.accepted", {31'd0, in_ready}, 32'd0);
    wait_out("bp2", 4);
    chk("bp2.sum",       sum,                32'h0000_000D);
    chk("bp2.c_out",     {31'd0, c_out},     32'd0);
    chk("bp2.over_flow", {31'd0, over_flow}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second CALC cycle
    a = 32'h1234_5678; b = 32'h0000_0001; sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.sum",       sum,                32'd0);
    run_op("after_rst_3_4", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
